// File: rtl/program_memory_loader_pkg.sv
// Shared types for the boot-time program memory loader.
// FSM state encoding, error codes and the byte-accepting state predicate.
package program_memory_loader_pkg;

    typedef enum logic [2:0] {
        ST_CNT_HI = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    function automatic logic takes_byte(state_e s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte stream in, program memory write port and boot status out.
// master = stream source / system side, slave = the loader.
interface program_memory_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;
    logic [1:0]            err_code;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, load_done, load_error, err_code
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, load_done, load_error, err_code
    );
endinterface

// File: rtl/program_memory_loader_word_assembler.sv
// Big-endian byte-to-word shifter; word is valid together with the 4th byte.
// word_full flags that the byte being pushed now completes the word.
module program_memory_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    assign word      = {shift_q, byte_in};
    assign word_full = (idx_q == 2'd3);

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (push) begin
            shift_d = {shift_q[15:0], byte_in};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/program_memory_loader.sv
// Boot loader: count header, big-endian words, XOR checksum byte.
// Keeps the core in reset until the whole image is written and verified.
module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = '0
) (
    input logic                   clk,
    input logic                   reset,
    program_memory_loader_if.slave bus
);
    localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

    state_e                state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            xor_q, xor_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic        fire;
    logic        asm_push;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        asm_full;
    logic [15:0] count_w;

    assign bus.byte_ready = !reset && takes_byte(state_q);
    assign fire     = bus.byte_valid && bus.byte_ready;
    assign asm_push = fire && (state_q == ST_DATA);
    assign count_w  = {cnt_hi_q, bus.byte_data};

    program_memory_loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .push      (asm_push),
        .byte_in   (bus.byte_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        asm_clear   = 1'b0;
        if (fire && state_q != ST_CHECK)
            xor_d = xor_q ^ bus.byte_data;
        case (state_q)
            ST_CNT_HI: if (fire) begin
                cnt_hi_d = bus.byte_data;
                state_d  = ST_CNT_LO;
            end
            ST_CNT_LO: if (fire) begin
                remaining_d = count_w;
                if (count_w > DEPTH_W) begin
                    state_d    = ST_ERROR;
                    error_d    = 1'b1;
                    err_code_d = ERR_OVF;
                end else if (count_w == 16'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (fire && asm_full) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = DATA_WIDTH'(asm_word);
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d      = addr_q + DATA_WIDTH'(4);
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: if (fire) begin
                if (bus.byte_data == xor_q) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    state_d    = ST_ERROR;
                    error_d    = 1'b1;
                    err_code_d = ERR_CSUM;
                end
            end
            ST_DONE, ST_ERROR: if (bus.start) begin
                state_d    = ST_CNT_HI;
                cpu_hold_d = 1'b1;
                done_d     = 1'b0;
                error_d    = 1'b0;
                err_code_d = ERR_NONE;
                addr_d     = BASE_ADDR;
                xor_d      = '0;
                asm_clear  = 1'b1;
            end
            default: state_d = ST_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CNT_HI;
            cnt_hi_q    <= '0;
            remaining_q <= '0;
            addr_q      <= BASE_ADDR;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = error_q;
    assign bus.err_code   = err_code_q;
endmodule
